instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the processor fetch stage. It replaces the reset-time hard-coded ROM with a clocked, synchronously-read RAM. After reset, a sequenced clear engine zeroes the array. A streaming load port then writes programs at run time. The fetch port uses a valid/ready handshake with one-cycle read latency, so the core can stall on it during clear or load.

Parameters:
DATA_W, 19, instruction word width in bits
ADDR_W, 12, address width; depth DEPTH = 2**ADDR_W words
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clear, contents undefined until loaded

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (sampled at posedge clk; 0 = reset)
fetch_req  in  1  core requests an instruction
fetch_addr  in  ADDR_W  word address of the fetch
fetch_ready  out  1  controller can accept a fetch this cycle
instr  out  DATA_W  fetched instruction word
instr_valid  out  1  instr holds data for the fetch accepted last cycle
load_start  in  1  begin a program load at load_base
load_base  in  ADDR_W  first word address of the load
load_valid  in  1  load_data is valid
load_data  in  DATA_W  word to write
load_last  in  1  qualifies the final word of the load (with load_valid)
load_ready  out  1  load port can accept a word
busy  out  1  state is CLEAR or LOAD

Behaviour:
- States: CLEAR, IDLE, LOAD. One-hot or binary encoding is free.
- Reset (rst==0 at posedge clk):
  - state=CLEAR; clr_ptr=0; wr_ptr=0.
  - instr=0, instr_valid=0, fetch_ready=0, load_ready=0, busy=1.
  - Reset wins over every other input. It aborts an in-progress load or clear immediately; partially written words are not restored.
- CLEAR (CLEAR_ON_RESET=1):
  - Each cycle, mem[clr_ptr]<=0 and clr_ptr++.
  - After writing clr_ptr==DEPTH-1, go to IDLE.
  - Exactly DEPTH cycles in CLEAR.
  - fetch_req and load_start are ignored.
- CLEAR (CLEAR_ON_RESET=0): one cycle in CLEAR, then IDLE; no writes.
- IDLE:
  - fetch_ready=1, load_ready=0, busy=0.
  - A fetch is accepted when fetch_req && fetch_ready at a posedge. On the next cycle, instr=mem[fetch_addr] and instr_valid=1.
  - Back-to-back fetches give one word per cycle.
  - Cycles with no accepted fetch: instr_valid=0 next cycle, and instr holds its last value.
- load_start in IDLE:
  - wr_ptr<=load_base; go to LOAD next cycle.
  - If fetch_req is also high in that cycle, the fetch is still accepted and returns pre-load contents.
- LOAD:
  - fetch_ready=0, load_ready=1, busy=1.
  - Each cycle with load_valid: mem[wr_ptr]<=load_data and wr_ptr<=wr_ptr+1, modulo DEPTH (wraps DEPTH-1 to 0, no error).
  - load_valid && load_last: write that word, return to IDLE next cycle.
  - Cycles without load_valid: no write, stay in LOAD.
  - load_start in LOAD is ignored.
- Read latency is exactly 1 cycle from acceptance. No read/write hazard exists, because fetches are never accepted in LOAD or CLEAR.
- In IDLE after load completion, a fetch of any loaded address returns the loaded word.
- The array is one RAM with one write port and one synchronous read port; no reset of the array other than the CLEAR sequence.

Test Plan:
- Use ADDR_W=4, DATA_W=19 for all scenarios.
- Reset/clear: hold rst=0 for 2 cycles, release -> busy=1 for exactly 16 cycles, then fetch_ready=1. Fetch addr 0..15 -> each instr=0. During reset, instr_valid=0 and instr=0.
- Load + fetch: load_base=2, stream 19'b1110000000000001000, 19'b0101001000100000101, 19'b0111001100000010001 with load_last on the third word. Fetch 2,3,4 back-to-back -> those words on 3 consecutive cycles, instr_valid high each cycle. Fetch 5 -> 0.
- Wrap-around: load_base=15, two words A,B with load_last on B -> mem[15]=A, mem[0]=B. Fetch 15 then 0 returns A then B.
- Stall/handshake: fetch_req held during LOAD -> fetch_ready=0, instr_valid=0, no accept. Load with gaps in load_valid -> only valid words written. fetch_req and load_start in same cycle -> old data returned, then LOAD entered.
- Reset mid-operation: assert rst=0 after 1 of 3 load words -> CLEAR restarts, all words read 0 afterwards. Reset during CLEAR at clr_ptr=7 -> CLEAR restarts from 0 and lasts a full 16 cycles.
- CLEAR_ON_RESET=0: after reset release, fetch_ready=1 on the second cycle.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch stage: synchronous-read RAM with a post-reset
// clear sequencer, a streaming program-load port and a valid/ready fetch port.
module instr_mem_ctrl #(
  parameter int DATA_W         = 19,
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0]   instr_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                fetch_acc;

  logic [DATA_W-1:0]   mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = load_data;
    fetch_acc = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET) begin
          mem_we    = 1'b1;
          mem_waddr = clr_ptr_q;
          mem_wdata = '0;
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
          if (clr_ptr_q == '1) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // A fetch in the same cycle as load_start still reads pre-load contents.
        fetch_acc = fetch_req;
        if (load_start) begin
          wr_ptr_d = load_base;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (load_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    instr_valid_d = fetch_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Reset blocks array writes so an aborted load or clear leaves words as they were.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)           instr_q <= '0;
    else if (fetch_acc) instr_q <= mem[fetch_addr];
  end

  assign fetch_ready = (state_q == ST_IDLE);
  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: a driver updates an array model of the
// memory and queues expected fetch words; a negedge monitor pops and compares.
module tb_instr_mem_ctrl;
  localparam int DW    = 19;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          busy;

  logic          fr0, iv0, lr0, busy0;
  logic [DW-1:0] instr0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .instr(instr), .instr_valid(instr_valid),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready), .busy(busy)
  );

  instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_noclr (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fr0), .instr(instr0), .instr_valid(iv0),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(lr0), .busy(busy0)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_exp;
  logic [DW-1:0] ld_q[$];
  int            cyc = 0;
  int            n_pass = 0;
  int            n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (rst) begin
      if (instr_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_instr_valid", instr_valid, 0);
        end else begin
          e = sb.pop_front();
          check("instr_data", instr, e.data);
          check("instr_latency", cyc, e.cyc);
          last_exp = e.data;
        end
      end else begin
        check("instr_hold", instr, last_exp);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          check("missing_instr_valid", instr_valid, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    int cnt;
    rst = 1'b0;
    idle_inputs();
    last_exp = '0;
    repeat (hold) begin
      tick();
      check("reset_instr_valid", instr_valid, 0);
      check("reset_instr", instr, 0);
      check("reset_busy", busy, 1);
      check("reset_fetch_ready", fetch_ready, 0);
    end
    rst = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (cnt == 0) check("noclr_ready_cycle1", fr0, 0);
      if (cnt == 1) check("noclr_ready_cycle2", fr0, 1);
      cnt++;
      tick();
    end
    check("clear_cycles", cnt, 16);
    check("ready_after_clear", fetch_ready, 1);
    check("load_ready_idle", load_ready, 0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    check("fetch_ready_idle", fetch_ready, 1);
    fetch_req  = 1'b1;
    fetch_addr = a;
    sb.push_back('{data: model_mem[a], cyc: cyc + 1});
    tick();
  endtask

  task automatic drain();
    idle_inputs();
    tick();
    tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic fetch_all();
    for (int i = 0; i < DEPTH; i++) fetch(AW'(i));
    drain();
  endtask

  // Streams ld_q starting at base; optional gaps, held fetch_req, or a fetch in the start cycle.
  task automatic load(input logic [AW-1:0] base, input bit gaps, input bit stall_fetch,
                      input bit with_fetch);
    int ptr;
    logic [AW-1:0] fa;
    int n;
    n = ld_q.size();
    load_start = 1'b1;
    load_base  = base;
    if (with_fetch) begin
      fa = AW'($urandom_range(0, DEPTH - 1));
      fetch_req  = 1'b1;
      fetch_addr = fa;
      sb.push_back('{data: model_mem[fa], cyc: cyc + 1});
    end
    tick();
    load_start = 1'b0;
    fetch_req  = stall_fetch;
    fetch_addr = AW'($urandom_range(0, DEPTH - 1));
    check("load_ready_in_load", load_ready, 1);
    check("fetch_ready_in_load", fetch_ready, 0);
    check("busy_in_load", busy, 1);
    ptr = int'(base);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          load_data  = DW'($urandom);
          load_last  = 1'($urandom);
          load_start = 1'($urandom);
          load_base  = AW'($urandom);
          tick();
          check("load_ready_gap", load_ready, 1);
        end
      end
      load_start = 1'($urandom);
      load_base  = AW'($urandom);
      load_valid = 1'b1;
      load_data  = ld_q[i];
      load_last  = (i == n - 1);
      tick();
      model_mem[ptr] = ld_q[i];
      ptr = (ptr + 1) % DEPTH;
    end
    idle_inputs();
    check("fetch_ready_after_load", fetch_ready, 1);
    check("busy_after_load", busy, 0);
    ld_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] wa, wb;
    rst = 1'b0;
    fetch_addr = '0;
    load_base  = '0;
    load_data  = '0;
    idle_inputs();
    last_exp = '0;

    do_reset(2);
    fetch_all();

    ld_q = '{19'b1110000000000001000, 19'b0101001000100000101, 19'b0111001100000010001};
    load(AW'(2), 1'b0, 1'b0, 1'b0);
    fetch(AW'(2));
    fetch(AW'(3));
    fetch(AW'(4));
    fetch(AW'(5));
    drain();

    wa = DW'($urandom);
    wb = DW'($urandom);
    ld_q = '{wa, wb};
    load(AW'(15), 1'b0, 1'b0, 1'b0);
    fetch(AW'(15));
    fetch(AW'(0));
    drain();

    for (int i = 0; i < 4; i++) ld_q.push_back(DW'($urandom));
    load(AW'(6), 1'b1, 1'b1, 1'b0);
    drain();
    fetch_all();

    ld_q = '{DW'($urandom), DW'($urandom)};
    load(AW'(5), 1'b0, 1'b0, 1'b1);
    drain();
    fetch(AW'(5));
    fetch(AW'(6));
    drain();

    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) ld_q.push_back(DW'($urandom));
      load(AW'($urandom_range(0, DEPTH - 1)), 1'($urandom), 1'($urandom), 1'($urandom));
      drain();
      repeat (8) begin
        fetch(AW'($urandom_range(0, DEPTH - 1)));
        if ($urandom_range(0, 2) == 0) begin
          fetch_req = 1'b0;
          tick();
        end
      end
      drain();
    end

    load_start = 1'b1;
    load_base  = AW'(3);
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 19'h5A5A5;
    load_last  = 1'b0;
    tick();
    do_reset(2);
    fetch_all();

    for (int k = 0; k < DEPTH; k++) ld_q.push_back(DW'($urandom) | 19'h1);
    load(AW'(0), 1'b0, 1'b0, 1'b0);
    drain();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (7) tick();
    do_reset(1);
    fetch_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
